// File: rtl/bool_minterm_scanner.sv
// Enumerates, in ascending order, every input vector whose truth-table bit equals target.
// Optional match counter is built only when BOOL_SCAN_COUNT_EN is defined.
module bool_minterm_scanner #(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2**N-1:0] tt,
  input  logic            target,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N-1:0]    m_vec,
  output logic            busy,
  output logic            done,
  output logic [N:0]      match_count
);

  localparam logic [N-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

  state_t          state, state_nx;
  logic [2**N-1:0] tt_q, tt_nx;
  logic            tgt_q, tgt_nx;
  logic [N-1:0]    idx, idx_nx;
  logic            m_valid_nx;
  logic [N-1:0]    m_vec_nx;
  logic            cnt_clr, cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tt_q    <= '0;
      tgt_q   <= 1'b0;
      idx     <= '0;
      m_valid <= 1'b0;
      m_vec   <= '0;
    end else begin
      state   <= state_nx;
      tt_q    <= tt_nx;
      tgt_q   <= tgt_nx;
      idx     <= idx_nx;
      m_valid <= m_valid_nx;
      m_vec   <= m_vec_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    tt_nx      = tt_q;
    tgt_nx     = tgt_q;
    idx_nx     = idx;
    m_valid_nx = m_valid;
    m_vec_nx   = m_vec;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        tt_nx    = tt;
        tgt_nx   = target;
        idx_nx   = '0;
        cnt_clr  = 1'b1;
        state_nx = SCAN;
      end
      SCAN: begin
        if (tt_q[idx] == tgt_q) begin
          m_vec_nx   = idx;
          m_valid_nx = 1'b1;
          state_nx   = HOLD;
        end else if (idx == LAST) begin
          state_nx = DONE;
        end else begin
          idx_nx = idx + N'(1);
        end
      end
      HOLD: if (m_valid && m_ready) begin
        m_valid_nx = 1'b0;
        cnt_inc    = 1'b1;
        // terminal test keeps idx from wrapping past the last vector
        if (idx == LAST) state_nx = DONE;
        else begin
          idx_nx   = idx + N'(1);
          state_nx = SCAN;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

`ifdef BOOL_SCAN_COUNT_EN
  logic [N:0] cnt_q;

  // N+1 bits so an all-match table reports 2^N without overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (cnt_clr) cnt_q <= '0;
    else if (cnt_inc) cnt_q <= cnt_q + (N+1)'(1);
  end

  assign match_count = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt  = cnt_clr ^ cnt_inc;
  assign match_count = '0;
`endif

endmodule

// File: doc/bool_minterm_scanner.md
# bool_minterm_scanner

Sequential inverse of the team's 4-input combinational Boolean function blocks: instead of mapping an input vector to an output bit, it takes a function's full truth table and streams out every input vector that produces a requested output value, in ascending order. Each vector is emitted over a valid/ready handshake. It sits beside the combinational function blocks as a solver/enumerator for test generation and minterm listing.

## Interface
- N, default 4: number of function inputs. Truth table width is 2^N.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- tt  in  2^N  truth table; bit i = f(vector i). Sampled on accepted start.
- target  in  1  output value to search for: 1 lists minterms, 0 lists maxterms. Sampled on accepted start.
- m_valid  out  1  m_vec holds a matching vector.
- m_ready  in  1  consumer accepts m_vec.
- m_vec  out  N  matching vector. For N=4, {a,b,c,d} = m_vec[3:0].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the scan completes.
- match_count  out  N+1  number of vectors emitted in the current or last scan.

## Operation
- States: IDLE, SCAN, HOLD, DONE.
- IDLE: start=1 latches tt into tt_q and target into tgt_q, clears idx and match_count, then goes to SCAN. start is ignored outside IDLE.
- SCAN, one index per cycle:
  - If tt_q[idx]==tgt_q: on the next edge m_vec<=idx, m_valid<=1, and the state goes to HOLD.
  - Otherwise, if idx==2^N-1 go to DONE; else idx<=idx+1.
- HOLD: m_valid and m_vec stay stable until m_valid&&m_ready. On that edge:
  - m_valid<=0 and match_count<=match_count+1.
  - If idx==2^N-1 go to DONE; else idx<=idx+1 and go to SCAN.
- DONE: done=1 for exactly one cycle, then IDLE. match_count holds until the next accepted start.
- idx is N bits wide and never wraps; the terminal test on idx==2^N-1 prevents wrap-around.
- match_count is N+1 bits wide, so it can represent 2^N (an all-match table).
- Changes on tt/target while busy have no effect.

## Timing
- Reset (async assert, sync release): state=IDLE, m_valid=0, m_vec=0, busy=0, done=0, match_count=0, idx=0.
- start sampled at edge k: busy=1 from k+1.
- If tt[0] matches: m_valid=1 from k+2.
- Unmatched index costs 1 cycle. Matched index costs 2 cycles plus any m_ready stall.
- Total scan (SCAN+HOLD cycles) with m_ready held high = 2^N + matches. DONE follows.
- m_ready may be high before m_valid; the handshake completes on the first HOLD edge.
- Reset mid-scan aborts immediately to reset values. No done pulse is produced.

## Configuration
- BOOL_SCAN_COUNT_EN
  - Defined: match_count counts as specified.
  - Undefined: the counter is not built and match_count is tied to 0. All other behaviour is identical.

## Test plan
- Minterm listing: tt=16'hEAAF (f=abc+a'b'+d), target=1, m_ready=1. Expect m_vec 0,1,2,3,5,7,9,11,13,14,15 in that order; done at 27 cycles after SCAN entry; match_count=11.
- Maxterm listing: same tt, target=0. Expect m_vec 4,6,8,10,12; match_count=5.
- Backpressure: tt=16'h8001, target=1, m_ready low for 5 cycles on each match. Expect m_vec=0 held stable for 5 cycles, then 15; no index skipped; done once.
- Edge tables:
  - tt=0, target=1: no m_valid; done after 16 SCAN cycles; count=0.
  - tt=16'hFFFF, target=1: 16 vectors; match_count=16 (no overflow).
- Robustness: start pulsed while busy is ignored. rst_n asserted while in HOLD: m_valid=0 asynchronously, state=IDLE, and a new start scans correctly.
- Build without BOOL_SCAN_COUNT_EN: rerun the first scenario; vectors are identical and match_count=0.
